// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: forwarding selects, hazard FSM states and
// the register/result-source constants used by the hazard logic.
package pipeline_pkg;

   typedef enum logic [1:0] {
      FWD_RD = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } hz_state_t;

   localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
   localparam logic [4:0] REG_ZERO        = 5'd0;

   // True when a writer register is a real (non-x0) register equal to the reader
   function automatic logic reg_match(input logic [4:0] i_rd, input logic [4:0] i_rs);
      return (i_rd != REG_ZERO) && (i_rd == i_rs);
   endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Operand forwarding select for one Execute source operand.
// Memory-stage result has priority over Writeback; x0 is never forwarded.
module hazard_fwd_unit
   import pipeline_pkg::*;
(
   input  logic [4:0] i_rs,
   input  logic [4:0] i_rd_m,
   input  logic [4:0] i_rd_w,
   input  logic       i_regwrite_m,
   input  logic       i_regwrite_w,
   output logic [1:0] o_fwd
);

   // Priority compare: M, then W, else register file
   always_comb begin
      o_fwd = FWD_RD;
      if (i_regwrite_m && reg_match(i_rd_m, i_rs))
         o_fwd = FWD_M;
      else if (i_regwrite_w && reg_match(i_rd_w, i_rs))
         o_fwd = FWD_W;
   end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: operand forwarding, load-use stall, branch
// flush and multi-cycle Execute sequencing.
// Optional build macro: HAZARD_PERF_EN enables saturating stall/flush
// performance counters; without it StallCount/FlushCount are tied to 0.
module hazard_controller
   import pipeline_pkg::*;
#(
   parameter int unsigned MULTI_LAT = 4
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  Rs1D,
   input  logic [4:0]  Rs2D,
   input  logic [4:0]  Rs1E,
   input  logic [4:0]  Rs2E,
   input  logic [4:0]  RdE,
   input  logic [4:0]  RdM,
   input  logic [4:0]  RdW,
   input  logic        RegWriteM,
   input  logic        RegWriteW,
   input  logic [1:0]  ResultSrcE,
   input  logic        PCSrcE,
   input  logic        MultiStartE,
   output logic [1:0]  ForwardAE,
   output logic [1:0]  ForwardBE,
   output logic        StallF,
   output logic        StallD,
   output logic        StallE,
   output logic        FlushD,
   output logic        FlushE,
   output logic        FlushM,
   output logic        MultiDoneE,
   output logic [15:0] StallCount,
   output logic [15:0] FlushCount
);

   localparam logic [3:0] LOAD_CNT = 4'(MULTI_LAT - 2);

   hz_state_t  r_state;
   logic [3:0] r_cnt;
   logic       w_load_use;
   logic       w_multi_start;

   hazard_fwd_unit u_fwd_a (
      .i_rs         (Rs1E),
      .i_rd_m       (RdM),
      .i_rd_w       (RdW),
      .i_regwrite_m (RegWriteM),
      .i_regwrite_w (RegWriteW),
      .o_fwd        (ForwardAE)
   );

   hazard_fwd_unit u_fwd_b (
      .i_rs         (Rs2E),
      .i_rd_m       (RdM),
      .i_rd_w       (RdW),
      .i_regwrite_m (RegWriteM),
      .i_regwrite_w (RegWriteW),
      .o_fwd        (ForwardBE)
   );

   assign w_load_use = (ResultSrcE == RESULT_SRC_LOAD) &&
                       (reg_match(RdE, Rs1D) || reg_match(RdE, Rs2D));

   // A taken branch in the same cycle kills the multi-cycle op, so it never starts
   assign w_multi_start = MultiStartE && !PCSrcE;

   // Multi-cycle sequencer: the start cycle is spent in IDLE and counts as
   // occupancy cycle 1, so BUSY lasts MULTI_LAT-1 cycles (cnt from MULTI_LAT-2 to 0)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_multi_start) begin
                  r_state <= BUSY;
                  r_cnt   <= LOAD_CNT;
               end
            end
            BUSY: begin
               if (r_cnt == '0)
                  r_state <= IDLE;
               else
                  r_cnt <= r_cnt - 4'd1;
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // Stall/flush decode from current state and inputs; all quiet during reset.
   // The start cycle already holds E so total occupancy is exactly MULTI_LAT.
   always_comb begin
      StallF     = 1'b0;
      StallD     = 1'b0;
      StallE     = 1'b0;
      FlushD     = 1'b0;
      FlushE     = 1'b0;
      FlushM     = 1'b0;
      MultiDoneE = 1'b0;
      if (reset) begin
         case (r_state)
            IDLE: begin
               if (PCSrcE) begin
                  FlushD = 1'b1;
                  FlushE = 1'b1;
               end else if (MultiStartE) begin
                  StallF = 1'b1;
                  StallD = 1'b1;
                  StallE = 1'b1;
                  FlushM = 1'b1;
               end else if (w_load_use) begin
                  StallF = 1'b1;
                  StallD = 1'b1;
                  FlushE = 1'b1;
               end
            end
            BUSY: begin
               if (r_cnt == '0) begin
                  MultiDoneE = 1'b1;
               end else begin
                  StallF = 1'b1;
                  StallD = 1'b1;
                  StallE = 1'b1;
                  FlushM = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef HAZARD_PERF_EN
   logic [15:0] r_stall_cnt;
   logic [15:0] r_flush_cnt;

   // Saturating performance counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (StallF && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 16'd1;
         if ((FlushD || FlushE || FlushM) && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + 16'd1;
      end
   end

   assign StallCount = r_stall_cnt;
   assign FlushCount = r_flush_cnt;
`else
   assign StallCount = '0;
   assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller (MULTI_LAT=4 and 8 instances).
module tb_hazard_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic        RegWriteM, RegWriteW, PCSrcE, MultiStartE;
   logic [1:0]  ResultSrcE;

   logic [1:0]  fa4, fb4, fa8, fb8;
   logic        sf4, sd4, se4, fd4, fe4, fm4, md4;
   logic        sf8, sd8, se8, fd8, fe8, fm8, md8;
   logic [15:0] sc4, fc4, sc8, fc8;
   logic [6:0]  ctl4, ctl8;

   int checks = 0;
   int errors = 0;

   // {StallF,StallD,StallE,FlushD,FlushE,FlushM,MultiDoneE}
   assign ctl4 = {sf4, sd4, se4, fd4, fe4, fm4, md4};
   assign ctl8 = {sf8, sd8, se8, fd8, fe8, fm8, md8};

   localparam logic [6:0] C_NONE  = 7'b000_000_0;
   localparam logic [6:0] C_LU    = 7'b110_010_0;
   localparam logic [6:0] C_BR    = 7'b000_110_0;
   localparam logic [6:0] C_MULTI = 7'b111_001_0;
   localparam logic [6:0] C_DONE  = 7'b000_000_1;

   always #5 clk = ~clk;

   hazard_controller #(.MULTI_LAT(4)) u4 (
      .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MultiStartE(MultiStartE),
      .ForwardAE(fa4), .ForwardBE(fb4), .StallF(sf4), .StallD(sd4), .StallE(se4),
      .FlushD(fd4), .FlushE(fe4), .FlushM(fm4), .MultiDoneE(md4),
      .StallCount(sc4), .FlushCount(fc4));

   hazard_controller #(.MULTI_LAT(8)) u8 (
      .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MultiStartE(MultiStartE),
      .ForwardAE(fa8), .ForwardBE(fb8), .StallF(sf8), .StallD(sd8), .StallE(se8),
      .FlushD(fd8), .FlushE(fe8), .FlushM(fm8), .MultiDoneE(md8),
      .StallCount(sc8), .FlushCount(fc8));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
      RdE = '0; RdM = '0; RdW = '0;
      RegWriteM = 1'b0; RegWriteW = 1'b0;
      ResultSrcE = '0; PCSrcE = 1'b0; MultiStartE = 1'b0;
   endtask

   task automatic set_load_use();
      ResultSrcE = 2'b01; RdE = 5'd5; Rs2D = 5'd5;
   endtask

   task automatic do_reset();
      clear_in();
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      clear_in();
      #1;
      reset = 1'b0;
      Rs1E = 5'd3; RdM = 5'd3; RegWriteM = 1'b1;
      MultiStartE = 1'b1;
      set_load_use();
      #2;
      checks++;
      if (ctl4 !== C_NONE) begin
         errors++; $display("FAIL reset_ctl4 got %b want %b", ctl4, C_NONE);
      end
      checks++;
      if (fa4 !== 2'b10) begin
         errors++; $display("FAIL reset_fwdA got %b want 10", fa4);
      end
      checks++;
      if ({sc4, fc4} !== 32'd0) begin
         errors++; $display("FAIL reset_counters got %h/%h want 0/0", sc4, fc4);
      end
      tick();
      #2;
      checks++;
      if (ctl8 !== C_NONE) begin
         errors++; $display("FAIL reset_ctl8 got %b want %b", ctl8, C_NONE);
      end
      clear_in();
      reset = 1'b1;
      tick();
   endtask

   typedef struct packed {
      logic [4:0] rs1e, rs2e, rdm, rdw;
      logic       rwm, rww;
      logic [1:0] ea, eb;
   } fwd_vec_t;

   task automatic test_forward();
      fwd_vec_t v [7];
      v = '{
         '{5'd3,  5'd0,  5'd3,  5'd3,  1'b1, 1'b1, 2'b10, 2'b00},
         '{5'd3,  5'd0,  5'd3,  5'd3,  1'b0, 1'b1, 2'b01, 2'b00},
         '{5'd0,  5'd0,  5'd3,  5'd3,  1'b1, 1'b1, 2'b00, 2'b00},
         '{5'd0,  5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 2'b00, 2'b00},
         '{5'd4,  5'd9,  5'd9,  5'd4,  1'b1, 1'b1, 2'b01, 2'b10},
         '{5'd4,  5'd9,  5'd9,  5'd4,  1'b0, 1'b0, 2'b00, 2'b00},
         '{5'd31, 5'd31, 5'd31, 5'd31, 1'b0, 1'b1, 2'b01, 2'b01}
      };
      clear_in();
      for (int i = 0; i < 7; i++) begin
         Rs1E = v[i].rs1e; Rs2E = v[i].rs2e; RdM = v[i].rdm; RdW = v[i].rdw;
         RegWriteM = v[i].rwm; RegWriteW = v[i].rww;
         #2;
         checks++;
         if ({fa4, fb4} !== {v[i].ea, v[i].eb}) begin
            errors++;
            $display("FAIL fwd_vec%0d got A=%b B=%b want A=%b B=%b", i, fa4, fb4, v[i].ea, v[i].eb);
         end
      end
      clear_in();
      tick();
   endtask

   task automatic test_load_use();
      do_reset();
      set_load_use();
      #2;
      checks++;
      if (ctl4 !== C_LU) begin
         errors++; $display("FAIL lu_rs2 got %b want %b", ctl4, C_LU);
      end
      tick();
      clear_in();
      #2;
      checks++;
      if (ctl4 !== C_NONE) begin
         errors++; $display("FAIL lu_one_cycle got %b want %b", ctl4, C_NONE);
      end
      ResultSrcE = 2'b01; RdE = 5'd7; Rs1D = 5'd7;
      #2;
      checks++;
      if (ctl4 !== C_LU) begin
         errors++; $display("FAIL lu_rs1 got %b want %b", ctl4, C_LU);
      end
      clear_in();
      ResultSrcE = 2'b01; RdE = 5'd0; Rs2D = 5'd0;
      #2;
      checks++;
      if (ctl4 !== C_NONE) begin
         errors++; $display("FAIL lu_x0 got %b want %b", ctl4, C_NONE);
      end
      clear_in();
      ResultSrcE = 2'b00; RdE = 5'd5; Rs2D = 5'd5;
      #2;
      checks++;
      if (ctl4 !== C_NONE) begin
         errors++; $display("FAIL lu_notload got %b want %b", ctl4, C_NONE);
      end
      clear_in();
      tick();
   endtask

   task automatic test_branch_vs_load();
      do_reset();
      set_load_use();
      PCSrcE = 1'b1;
      #2;
      checks++;
      if (ctl4 !== C_BR) begin
         errors++; $display("FAIL br_vs_lu got %b want %b", ctl4, C_BR);
      end
      clear_in();
      tick();
   endtask

   task automatic test_multi();
      do_reset();
      MultiStartE = 1'b1;
      #2;
      checks++;
      if (ctl4 !== C_MULTI) begin
         errors++; $display("FAIL multi_c0 got %b want %b", ctl4, C_MULTI);
      end
      tick();
      for (int c = 1; c <= 2; c++) begin
         MultiStartE = 1'b1; PCSrcE = 1'b1;
         set_load_use();
         Rs1E = 5'd3; RdM = 5'd3; RegWriteM = 1'b1;
         #2;
         checks++;
         if (ctl4 !== C_MULTI) begin
            errors++; $display("FAIL multi_c%0d got %b want %b", c, ctl4, C_MULTI);
         end
         checks++;
         if (fa4 !== 2'b10) begin
            errors++; $display("FAIL multi_fwd_c%0d got %b want 10", c, fa4);
         end
         tick();
      end
      clear_in();
      #2;
      checks++;
      if (ctl4 !== C_DONE) begin
         errors++; $display("FAIL multi_c3_done got %b want %b", ctl4, C_DONE);
      end
      tick();
      #2;
      checks++;
      if (ctl4 !== C_NONE) begin
         errors++; $display("FAIL multi_c4_idle got %b want %b", ctl4, C_NONE);
      end
      set_load_use();
      #1;
      checks++;
      if (ctl4 !== C_LU) begin
         errors++; $display("FAIL multi_c4_lu got %b want %b", ctl4, C_LU);
      end
      clear_in();
      tick();
   endtask

   task automatic test_reset_mid_busy();
      do_reset();
      MultiStartE = 1'b1;
      tick();
      MultiStartE = 1'b0;
      #1;
      checks++;
      if (ctl8 !== C_MULTI) begin
         errors++; $display("FAIL rmb_busy got %b want %b", ctl8, C_MULTI);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (ctl8 !== C_NONE) begin
         errors++; $display("FAIL rmb_in_reset got %b want %b", ctl8, C_NONE);
      end
      tick();
      reset = 1'b1;
      #2;
      checks++;
      if (ctl8 !== C_NONE) begin
         errors++; $display("FAIL rmb_after got %b want %b", ctl8, C_NONE);
      end
      PCSrcE = 1'b1;
      #1;
      checks++;
      if (ctl8 !== C_BR) begin
         errors++; $display("FAIL rmb_idle_branch got %b want %b", ctl8, C_BR);
      end
      PCSrcE = 1'b0;
      tick();
      MultiStartE = 1'b1;
      for (int c = 0; c < 8; c++) begin
         #2;
         checks++;
         if (ctl8 !== ((c < 7) ? C_MULTI : C_DONE)) begin
            errors++;
            $display("FAIL rmb_lat8_c%0d got %b want %b", c, ctl8, (c < 7) ? C_MULTI : C_DONE);
         end
         tick();
         MultiStartE = 1'b0;
      end
      #2;
      checks++;
      if (ctl8 !== C_NONE) begin
         errors++; $display("FAIL rmb_lat8_end got %b want %b", ctl8, C_NONE);
      end
      tick();
   endtask

   task automatic test_perf();
      logic [15:0] exp_cnt;
`ifdef HAZARD_PERF_EN
      exp_cnt = 16'd3;
`else
      exp_cnt = 16'd0;
`endif
      do_reset();
      set_load_use();
      tick();
      tick();
      tick();
      clear_in();
      #2;
      checks++;
      if (sc4 !== exp_cnt) begin
         errors++; $display("FAIL perf_stall got %0d want %0d", sc4, exp_cnt);
      end
      checks++;
      if (fc4 !== exp_cnt) begin
         errors++; $display("FAIL perf_flush got %0d want %0d", fc4, exp_cnt);
      end
      tick();
      #2;
      checks++;
      if ({sc8, fc8} !== {exp_cnt, exp_cnt}) begin
         errors++; $display("FAIL perf_hold8 got %0d/%0d want %0d/%0d", sc8, fc8, exp_cnt, exp_cnt);
      end
   endtask

   initial begin
      clear_in();
      test_reset();
      test_forward();
      test_load_use();
      test_branch_vs_load();
      test_multi();
      test_reset_mid_busy();
      test_perf();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout reached got running want finished");
      $fatal(1, "timeout");
   end

endmodule
